// File: rtl/chan_sel_pkg.sv
// Shared constants for the channel selector family: mode encodings and
// default geometry used by chan_sel_reg and chan_sel_mux.
package chan_sel_pkg;

  localparam int NCH_DEF   = 6;
  localparam int WIDTH_DEF = 4;
  localparam int SELW_DEF  = 3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_sel_reg_if.sv
// Channel bank, select controls and valid/ready output handshake of the
// registered selector; slave is the selector, master is the surrounding logic.
interface chan_sel_reg_if
  import chan_sel_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
);

  logic [NCH*WIDTH-1:0] data;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;

  modport slave (
    input  data, sel, mode, in_valid, out_ready,
    output in_ready, out, out_ch, out_valid, sel_err
  );

  modport master (
    output data, sel, mode, in_valid, out_ready,
    input  in_ready, out, out_ch, out_valid, sel_err
  );

endinterface

// File: rtl/chan_sel_mux.sv
// Combinational N-way word selector; out-of-range indices give a zero word
// and raise range_err.
module chan_sel_mux
  import chan_sel_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic [NCH*WIDTH-1:0] data,
  input  logic [SELW-1:0]      idx,
  output logic [WIDTH-1:0]     word,
  output logic                 range_err
);

  localparam logic [SELW:0] NCH_EXT = (SELW+1)'(NCH);

  // NOTE: the default before the loop keeps this purely combinational; without
  // it an unmatched idx would infer a latch.
  always_comb begin
    word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) word = data[k*WIDTH +: WIDTH];
    end
  end

  // Extended by one bit so NCH == 2**SELW compares correctly.
  assign range_err = ({1'b0, idx} >= NCH_EXT);

endmodule

// File: rtl/chan_sel_reg.sv
// Registered N-channel selector with a one-entry valid/ready output stage,
// out-of-range flag and an auto-scan pointer that walks all channels.
module chan_sel_reg
  import chan_sel_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input logic          clk,
  input logic          resetn,
  chan_sel_reg_if.slave bus
);

  localparam logic [SELW:0] NCH_EXT = (SELW+1)'(NCH);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic [SELW:0]    ptr_inc;
  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic             accept;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign idx          = (bus.mode == MODE_SCAN) ? ptr : bus.sel;

  chan_sel_mux #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_mux (
    .data      (bus.data),
    .idx       (idx),
    .word      (mux_word),
    .range_err (mux_err)
  );

  // Increment one bit wider so the wrap compare cannot overflow at NCH == 2**SELW.
  assign ptr_inc  = {1'b0, ptr} + (SELW+1)'(1);
  assign ptr_next = (ptr_inc >= NCH_EXT) ? '0 : ptr_inc[SELW-1:0];

  // Pointer parks at 0 in direct mode so every scan starts at channel 0.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (bus.mode == MODE_DIRECT) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // Output stage: load on accept, drain on consumer take, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out       <= '0;
      bus.out_ch    <= '0;
      bus.sel_err   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out       <= mux_word;
      bus.out_ch    <= idx;
      bus.sel_err   <= mux_err;
      bus.out_valid <= 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_sel_reg.sv
// Directed bench for chan_sel_reg: direct select, range errors, stall,
// scan wrap, scan backpressure, mode restart and asynchronous reset mid-stall.
module tb_chan_sel_reg;

  localparam int NCH   = 6;
  localparam int WIDTH = 4;
  localparam int SELW  = 3;
  localparam logic [NCH*WIDTH-1:0] DATA_STD = 24'hFEDCBA;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  chan_sel_reg_if #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) bus ();

  chan_sel_reg #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int val, input int ch,
                           input int vld, input int err);
    check({tag, ".out"},       32'(bus.out),       32'(val));
    check({tag, ".out_ch"},    32'(bus.out_ch),    32'(ch));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    check({tag, ".sel_err"},   32'(bus.sel_err),   32'(err));
  endtask

  initial begin
    int scan_ch[8];
    int bp_rdy[6];
    int bp_ch[6];
    scan_ch = '{0, 1, 2, 3, 4, 5, 0, 1};
    bp_rdy  = '{1, 0, 1, 0, 1, 0};
    bp_ch   = '{2, 2, 3, 3, 4, 4};
    checks   = 0;
    failures = 0;

    resetn        = 1'b0;
    bus.data      = DATA_STD;
    bus.sel       = '0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    check_out("reset", 0, 0, 0, 0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);

    // Direct select sel=3
    @(negedge clk);
    resetn        = 1'b1;
    bus.sel       = 3'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("direct3", 'hD, 3, 1, 0);

    // Out of range, then back in range
    bus.sel = 3'd6;
    @(negedge clk);
    check_out("oor6", 0, 6, 1, 1);
    bus.sel = 3'd7;
    @(negedge clk);
    check_out("oor7", 0, 7, 1, 1);
    bus.sel = 3'd5;
    @(negedge clk);
    check_out("direct5", 'hF, 5, 1, 0);

    // Stall: capture channel 1, then hold while inputs change
    bus.sel = 3'd1;
    @(negedge clk);
    check_out("direct1", 'hB, 1, 1, 0);
    bus.out_ready = 1'b0;
    bus.sel       = 3'd4;
    bus.data      = 24'h123456;
    #1;
    check("stall.in_ready0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out("stall", 'hB, 1, 1, 0);
      check("stall.in_ready", 32'(bus.in_ready), 32'd0);
    end

    // Release with simultaneous drain and accept
    bus.data      = DATA_STD;
    bus.out_ready = 1'b1;
    bus.sel       = 3'd2;
    #1;
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_out("release", 'hC, 2, 1, 0);

    // Scan wrap at full throughput
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_out("scan", 'hA + scan_ch[i], scan_ch[i], 1, 0);
    end

    // Scan with backpressure: pointer moves only on accepts
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = bp_rdy[i][0];
      @(negedge clk);
      check_out("scan_bp", 'hA + bp_ch[i], bp_ch[i], 1, 0);
    end

    // Mode 0 drain cycle, then scan restarts at channel 0
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("drain", 'hE, 4, 0, 0);
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_out("restart0", 'hA, 0, 1, 0);
    @(negedge clk);
    check_out("restart1", 'hB, 1, 1, 0);

    // Stall, switch mode while holding: sample unchanged
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 3'd5;
    @(negedge clk);
    check_out("mode_hold", 'hB, 1, 1, 0);

    // Asynchronous reset between edges while stalled
    bus.mode = 1'b1;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0);
    check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    resetn        = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_out("post_rst0", 'hA, 0, 1, 0);
    @(negedge clk);
    check_out("post_rst1", 'hB, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_sel_reg.md
Name: chan_sel_reg

Overview:
- Parametrised, registered N-channel data selector; the next generation of the combinational 6-way 4-bit selector.
- Adds configurable channel count and width, a one-entry valid/ready output register, an out-of-range error flag and an auto-scan mode that walks all channels in turn.
- Sits between a bank of channel sources and a single downstream consumer that may stall.

Parameters:
- NCH, 6, number of input channels (2..64).
- WIDTH, 4, bits per channel.
- SELW, 3, select width; must satisfy 2**SELW >= NCH.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- data  in  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SELW  channel index, used in direct mode only
- mode  in  1  0 = direct (sel-driven), 1 = scan (internal pointer)
- in_valid  in  1  request to capture one sample
- in_ready  out  1  block can accept this cycle
- out  out  WIDTH  registered selected data
- out_ch  out  SELW  channel index that produced out
- out_valid  out  1  out/out_ch/sel_err hold a sample
- out_ready  in  1  consumer accepts the sample
- sel_err  out  1  held sample came from an out-of-range sel

Behaviour:
- Reset (resetn low, asynchronous): out=0, out_ch=0, out_valid=0, sel_err=0, scan pointer=0. in_ready=1 immediately.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept, at the same edge:
  - Effective index idx = sel (mode 0) or scan pointer (mode 1).
  - out <= data[idx] if idx < NCH, else 0.
  - out_ch <= idx.
  - sel_err <= (idx >= NCH).
  - out_valid <= 1.
- Latency is 1 cycle from accept to out_valid.
- If out_valid && out_ready && !in_valid: out_valid <= 0. out, out_ch and sel_err keep their last values.
- Stall: while out_valid && !out_ready, all outputs hold and in_ready=0. data changes during a stall are not reflected.
- Simultaneous drain and accept (out_valid, out_ready and in_valid all 1): the new sample loads and out_valid stays 1. Full throughput is one sample per cycle.
- Scan pointer:
  - Advances by 1 on each accept in mode 1.
  - Wraps NCH-1 -> 0.
  - Never takes an out-of-range value, so sel_err is always 0 in scan mode.
- Scan pointer in mode 0: held at 0, so entering scan mode always starts at channel 0.
- Mode change with a held sample: the sample is not modified. The new mode applies to the next accept.
- Reset mid-stall: the held sample is discarded and outputs return to reset values at once.
- Width rules:
  - idx compare is unsigned, SELW bits.
  - No arithmetic other than the pointer increment, which is computed SELW+1 wide before the wrap compare.

Decomposition:
- Package chan_sel_pkg holds:
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1 constants.
  - Default NCH/WIDTH/SELW localparams.
- Sub-module chan_sel_mux (combinational): data, idx -> selected word and range_err.
  - Zero and error for idx >= NCH.
  - Reused by other selectors in the codebase.
- Top-level holds the pointer, the output register and the handshake.

Test Plan:
- Reset and direct select:
  - Apply resetn=0 -> outputs 0, out_valid=0, in_ready=1.
  - Release reset. Drive NCH=6, data channels 0..5 = 4'hA,B,C,D,E,F, mode 0, sel=3, in_valid=1, out_ready=1.
  - Next cycle: out=4'hD, out_ch=3, out_valid=1, sel_err=0.
- Out of range: sel=6, then sel=7 -> out=0 with sel_err=1 for each; sel=5 next -> out=4'hF with sel_err=0.
- Stall:
  - Hold out_ready=0 after capturing sel=1 (4'hB). Change sel and data -> out stays 4'hB and in_ready=0 for 4 cycles.
  - Raise out_ready with in_valid=1, sel=2 -> out=4'hC on the next cycle with no bubble.
- Scan wrap: mode=1, in_valid and out_ready held at 1 for 8 cycles -> out_ch sequence 0,1,2,3,4,5,0,1 with matching data; sel_err stays 0.
- Scan with backpressure:
  - Toggle out_ready 1,0,1,0 in scan mode -> pointer advances only on accepts. No channel is skipped or duplicated.
  - Switch to mode 0 and back to mode 1 -> the scan restarts at channel 0.
- Async reset while out_valid=1 and stalled, asserted between clock edges -> out_valid drops to 0 immediately. The first scan after release starts at channel 0.
